// File: rtl/rca_chunk_seq.sv
// rca_chunk_seq: multi-cycle wide adder. A single N-bit ripple-carry adder is
// reused for CHUNKS cycles, least-significant chunk first, with the carry held
// in a register between chunks. valid/ready handshake on both sides.

// Plain N-bit ripple-carry adder, one full adder per bit.
module rca #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         cin_i,
   output logic [N-1:0] sum_o,
   output logic         cout_o
);
   logic [N:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = c[N];
endmodule

module rca_chunk_seq #(
   parameter int N      = 8,
   parameter int CHUNKS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*CHUNKS-1:0] a,
   input  logic [N*CHUNKS-1:0] b,
   input  logic                cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N*CHUNKS-1:0] sum,
   output logic                cout,
   output logic                busy
);
   localparam int W  = N * CHUNKS;
   // idx needs at least one bit even when there is only a single chunk
   localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q,   idx_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  opa_q,   opa_d;
   logic [W-1:0]  opb_q,   opb_d;
   logic [W-1:0]  sum_q,   sum_d;
   logic          cout_q,  cout_d;

   logic [N-1:0]  rca_a, rca_b, rca_s;
   logic          rca_co;

   // The shared adder always looks at the chunk selected by idx; its output
   // is only committed while in RUN.
   assign rca_a = opa_q[idx_q*N +: N];
   assign rca_b = opb_q[idx_q*N +: N];

   rca #(.N(N)) u_rca (
      .a_i    (rca_a),
      .b_i    (rca_b),
      .cin_i  (carry_q),
      .sum_o  (rca_s),
      .cout_o (rca_co)
   );

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;

   // Next-state logic: accept in IDLE, one chunk per edge in RUN, hold in DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               opa_d   = a;
               opb_d   = b;
               carry_d = cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[idx_q*N +: N] = rca_s;
            carry_d             = rca_co;
            if (idx_q == LAST_IDX) begin
               cout_d  = rca_co;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            // out_ready only matters once the result is actually on display
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end
endmodule

// File: tb/tb_rca_chunk_seq.sv
// Bench for rca_chunk_seq: three instances (N=8/CHUNKS=4, N=8/CHUNKS=1,
// N=4/CHUNKS=3) share operand wires but have private handshakes. Expected
// results come from plain (W+1)-bit integer addition.
module tb_rca_chunk_seq;
   logic        clk;
   logic        rst;
   logic [31:0] a, b;
   logic        cin;
   logic [2:0]  iv, ordy;
   logic [2:0]  ir, ov, co, bz;
   logic [31:0] sum0;
   logic [7:0]  sum1;
   logic [11:0] sum2;

   int total = 0;
   int bad   = 0;

   rca_chunk_seq #(.N(8), .CHUNKS(4)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(a), .b(b), .cin(cin), .out_valid(ov[0]), .out_ready(ordy[0]),
      .sum(sum0), .cout(co[0]), .busy(bz[0]));

   rca_chunk_seq #(.N(8), .CHUNKS(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov[1]), .out_ready(ordy[1]),
      .sum(sum1), .cout(co[1]), .busy(bz[1]));

   rca_chunk_seq #(.N(4), .CHUNKS(3)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(a[11:0]), .b(b[11:0]), .cin(cin), .out_valid(ov[2]), .out_ready(ordy[2]),
      .sum(sum2), .cout(co[2]), .busy(bz[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int width_of(input int d);
      case (d)
         0: return 32;
         1: return 8;
         default: return 12;
      endcase
   endfunction

   function automatic int chunks_of(input int d);
      case (d)
         0: return 4;
         1: return 1;
         default: return 3;
      endcase
   endfunction

   function automatic logic [63:0] result_of(input int d);
      case (d)
         0: return 64'({co[0], sum0});
         1: return 64'({co[1], sum1});
         default: return 64'({co[2], sum2});
      endcase
   endfunction

   // Golden model: exact integer sum of the operands truncated to W bits.
   function automatic logic [63:0] golden(input int d, input logic [31:0] av,
                                          input logic [31:0] bv, input logic c);
      logic [63:0] m;
      m = (64'd1 << width_of(d)) - 64'd1;
      return (64'(av) & m) + (64'(bv) & m) + 64'(c);
   endfunction

   // Drives one request to instance d, scrambles operands while it runs and
   // reports the result plus edges from accept to out_valid (-1 on timeout).
   task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                         input logic c, input int hold, input logic early,
                         output logic [63:0] res, output int lat);
      int k;
      ordy[d] = early;
      k = 0;
      while (!ir[d] && k < 50) begin
         @(negedge clk);
         k++;
      end
      a = av; b = bv; cin = c;
      iv[d] = 1'b1;
      @(negedge clk);
      iv[d] = 1'b0;
      lat = 0;
      while (!ov[d] && lat < 50) begin
         a = $urandom; b = $urandom; cin = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      if (!ov[d]) lat = -1;
      res = result_of(d);
      if (!early) begin
         for (int i = 0; i < hold; i++) @(negedge clk);
         ordy[d] = 1'b1;
      end
      @(negedge clk);
      ordy[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", ov[0]); end
      total++; if (sum0 !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h want=0", sum0); end
      total++; if (co[0] !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", co[0]); end
      total++; if (bz !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b want=000", bz); end
      total++; if (ir !== 3'b000) begin bad++; $display("FAIL reset_in_ready_in_rst got=%b want=000", ir); end
      rst = 1'b0;
      #1;
      total++; if (ir !== 3'b111) begin bad++; $display("FAIL reset_in_ready_after got=%b want=111", ir); end
   endtask

   task automatic test_carry_chain();
      logic [63:0] r; int lat;
      run_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, 1'b0, r, lat);
      total++; if (r !== 64'h1_0000_0000) begin bad++; $display("FAIL carry_chain_result got=%h want=100000000", r); end
      total++; if (lat !== 4) begin bad++; $display("FAIL carry_chain_latency got=%0d want=4", lat); end
   endtask

   task automatic test_pattern();
      logic [63:0] r; int lat;
      run_op(0, 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1, 1'b0, r, lat);
      total++; if (r !== 64'h0_0100_0101) begin bad++; $display("FAIL pattern_result got=%h want=001000101", r); end
      total++; if (lat !== 4) begin bad++; $display("FAIL pattern_latency got=%0d want=4", lat); end
   endtask

   task automatic test_backpressure();
      logic [63:0] exp_r; int k;
      exp_r = golden(0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
      ordy[0] = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1;
      iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      k = 0;
      while (!ov[0] && k < 50) begin @(negedge clk); k++; end
      total++; if (result_of(0) !== exp_r) begin bad++; $display("FAIL bp_result got=%h want=%h", result_of(0), exp_r); end
      for (int i = 0; i < 5; i++) begin
         iv[0] = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom);
         @(negedge clk);
         total++;
         if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || result_of(0) !== exp_r) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h",
                     i, ov[0], ir[0], result_of(0), exp_r);
         end
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      total++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
         bad++;
         $display("FAIL bp_release got ov=%b ir=%b busy=%b want ov=0 ir=1 busy=0", ov[0], ir[0], bz[0]);
      end
   endtask

   task automatic test_ready_early();
      logic [63:0] r; int lat;
      run_op(0, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 0, 1'b1, r, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL early_ready_latency got=%0d want=4", lat); end
      total++; if (r !== 64'h1_0000_0001) begin bad++; $display("FAIL early_ready_result got=%h want=100000001", r); end
      total++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin bad++; $display("FAIL early_ready_idle got ov=%b ir=%b want ov=0 ir=1", ov[0], ir[0]); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] r; int lat; int seen;
      ordy[0] = 1'b1;
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1;
      iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (bz[0] !== 1'b0 || ir[0] !== 1'b1) begin bad++; $display("FAIL mid_reset_idle got busy=%b ir=%b want busy=0 ir=1", bz[0], ir[0]); end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ov[0] === 1'b1) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL mid_reset_no_valid got=%0d want=0", seen); end
      ordy[0] = 1'b0;
      run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 2, 1'b0, r, lat);
      total++; if (r !== 64'h0_2345_6789) begin bad++; $display("FAIL after_reset_result got=%h want=023456789", r); end
   endtask

   task automatic test_random(input int d, input int n);
      logic [63:0] r, e; int lat; logic [31:0] av, bv; logic c;
      for (int i = 0; i < n; i++) begin
         av = $urandom; bv = $urandom; c = 1'($urandom);
         if (i % 10 == 0) begin av = 32'hFFFF_FFFF; bv = 32'h0; c = 1'b1; end
         e = golden(d, av, bv, c);
         run_op(d, av, bv, c, int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), r, lat);
         total++;
         if (r !== e || lat !== chunks_of(d)) begin
            bad++;
            $display("FAIL random d=%0d i=%0d a=%h b=%h cin=%b got=%h lat=%0d want=%h lat=%0d",
                     d, i, av, bv, c, r, lat, e, chunks_of(d));
         end
      end
   endtask

   initial begin
      rst = 1'b1; iv = '0; ordy = '0; a = '0; b = '0; cin = 1'b0;
      test_reset();
      test_carry_chain();
      test_pattern();
      test_backpressure();
      test_ready_early();
      test_reset_mid();
      test_random(0, 200);
      test_random(1, 100);
      test_random(2, 100);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
